perf_event_monitor: RTL and testbench

- Parametrised pipeline event monitor that sits beside the CPU and counts the core's cycles plus NUM_CH event strobes (stall, flush, retire, ...) in hardware.
- Bounded by a programmable cycle limit, with a snapshot/shadow register bank and a registered read port.
- Replaces ad-hoc stall/flush counting with a synthesizable block that the CPU top and the bench both observe.

---
 rtl/perf_event_monitor.sv | 137 +++++++++++++
 tb/tb_perf_event_monitor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_monitor.sv
// Cycle and event-strobe monitor with a programmable cycle limit, a shadow snapshot bank and a
// registered read port. Define PERF_WRAP_EN for counters that wrap instead of saturating.
module perf_event_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned LIMIT  = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         clear_i,
    input  logic [NUM_CH-1:0]            event_i,
    input  logic                         snap_i,
    input  logic                         rd_req_i,
    input  logic [$clog2(NUM_CH+1)-1:0]  rd_sel_i,
    output logic                         rd_valid_o,
    output logic [CNT_W-1:0]             rd_data_o,
    output logic [NUM_CH:0]              ovf_o,
    output logic [1:0]                   state_o,
    output logic                         done_o
);

    localparam int unsigned SelW   = $clog2(NUM_CH + 1);
    localparam int unsigned NumCnt = NUM_CH + 1;
    localparam int unsigned CmpW   = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [CmpW-1:0] LimitVal = CmpW'(LIMIT);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q    [NumCnt];
    logic [CNT_W-1:0] cnt_upd  [NumCnt];
    logic [CNT_W-1:0] cnt_d    [NumCnt];
    logic [CNT_W-1:0] shadow_q [NumCnt];
    logic [NUM_CH:0]  ovf_q, ovf_upd, ovf_d;
    logic [NUM_CH:0]  ev_all, hit;
    logic             limit_hit;
    logic [CNT_W-1:0] rd_mux;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q;

    // Top bit is the cycle counter, which counts every RUN cycle.
    assign ev_all = {1'b1, event_i};
    assign hit    = ev_all & {NumCnt{state_q == StRun}};

    always_comb begin
        ovf_upd = ovf_q;
        for (int k = 0; k < NumCnt; k++) begin
            cnt_upd[k] = cnt_q[k];
            if (hit[k]) begin
                if (&cnt_q[k]) begin
                    ovf_upd[k] = 1'b1;
                end
`ifdef PERF_WRAP_EN
                cnt_upd[k] = cnt_q[k] + CNT_W'(1);
`else
                if (!(&cnt_q[k])) begin
                    cnt_upd[k] = cnt_q[k] + CNT_W'(1);
                end
`endif
            end
        end
    end

    assign limit_hit = (LIMIT != 0) && hit[NUM_CH] && (CmpW'(cnt_upd[NUM_CH]) == LimitVal);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_upd;
        ovf_d   = ovf_upd;
        unique case (state_q)
            StIdle: if (start_i) state_d = StRun;
            StRun: begin
                if (limit_hit) begin
                    state_d = StHalt;
                end else if (!start_i) begin
                    state_d = StIdle;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
        // Clear wins over start and over the limit transition; the shadow bank is untouched.
        if (clear_i) begin
            state_d = StIdle;
            ovf_d   = '0;
            for (int k = 0; k < NumCnt; k++) begin
                cnt_d[k] = '0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NumCnt; k++) begin
            if (rd_sel_i == SelW'(k)) begin
                rd_mux = shadow_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int k = 0; k < NumCnt; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_mux;
            end
            // Snapshot takes this cycle's increments, even when a clear coincides.
            if (snap_i) begin
                shadow_q <= cnt_upd;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign ovf_o      = ovf_q;
    assign state_o    = state_q;
    assign done_o     = (state_q == StHalt);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench for perf_event_monitor: a 32-bit instance with LIMIT=64 checked against a
// cycle-level reference model, plus a 4-bit unlimited instance for the saturate/wrap rule.
module tb_perf_event_monitor;

    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;
    localparam longint LIM  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, clear = 1'b0, snap = 1'b0, rd_req = 1'b0;
    logic [3:0]  ev = '0;
    logic [2:0]  rd_sel = '0;
    logic        rd_valid, done;
    logic [31:0] rd_data;
    logic [4:0]  ovf;
    logic [1:0]  state;

    logic        w_start = 1'b0, w_clear = 1'b0, w_snap = 1'b0, w_rd_req = 1'b0;
    logic [3:0]  w_ev = '0;
    logic [2:0]  w_sel = '0;
    logic        w_rd_valid, w_done;
    logic [3:0]  w_rd_data;
    logic [4:0]  w_ovf;
    logic [1:0]  w_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    perf_event_monitor #(.NUM_CH(4), .CNT_W(32), .LIMIT(64)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
        .snap_i(snap), .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_valid_o(rd_valid),
        .rd_data_o(rd_data), .ovf_o(ovf), .state_o(state), .done_o(done)
    );

    perf_event_monitor #(.NUM_CH(4), .CNT_W(4), .LIMIT(0)) u_w (
        .clk_i(clk), .rst_i(rst), .start_i(w_start), .clear_i(w_clear), .event_i(w_ev),
        .snap_i(w_snap), .rd_req_i(w_rd_req), .rd_sel_i(w_sel), .rd_valid_o(w_rd_valid),
        .rd_data_o(w_rd_data), .ovf_o(w_ovf), .state_o(w_state), .done_o(w_done)
    );

    // Reference model of the 32-bit instance; m_state: 0 idle, 1 run, 2 halt.
    longint m_cnt[5];
    longint m_shadow[5];
    bit [4:0] m_ovf;
    int       m_state;
    bit       m_rd_valid;
    longint   m_rd_data;

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_cnt[k] = 0;
            m_shadow[k] = 0;
        end
        m_ovf = '0;
        m_state = 0;
        m_rd_valid = 0;
        m_rd_data = 0;
    endtask

    task automatic model_step();
        longint   nxt[5];
        bit [4:0] novf;
        bit [4:0] ev_ext;
        ev_ext = {1'b1, ev};
        novf = m_ovf;
        for (int k = 0; k < 5; k++) begin
            nxt[k] = m_cnt[k];
            if (m_state == 1 && ev_ext[k]) begin
                if (m_cnt[k] == MAXV) novf[k] = 1'b1;
`ifdef PERF_WRAP_EN
                nxt[k] = (m_cnt[k] + 1) % (MAXV + 1);
`else
                nxt[k] = (m_cnt[k] < MAXV) ? m_cnt[k] + 1 : MAXV;
`endif
            end
        end
        m_rd_valid = rd_req;
        if (rd_req) m_rd_data = (rd_sel <= 4) ? m_shadow[rd_sel] : 0;
        if (snap) m_shadow = nxt;
        if (clear) begin
            for (int k = 0; k < 5; k++) m_cnt[k] = 0;
            m_ovf = '0;
            m_state = 0;
        end else begin
            if (m_state == 0 && start) m_state = 1;
            else if (m_state == 1) begin
                if (nxt[4] == LIM) m_state = 2;
                else if (!start) m_state = 0;
            end
            m_cnt = nxt;
            m_ovf = novf;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        snap = 0; clear = 0; rd_req = 0;
        w_snap = 0; w_clear = 0; w_rd_req = 0;
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", done); end
        checks++; if (ovf !== 5'b0) begin errors++; $display("FAIL reset_ovf got %0h want 0", ovf); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0d want 0", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
        rd_req = 1; rd_sel = 3'd4;
        tick();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL reset_read_valid got %0d want 1", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_shadow got %0d want 0", rd_data); end
    endtask

    task automatic test_limit();
        int n;
        int exp_v[5];
        exp_v = '{64, 0, 0, 0, 64};
        clear = 1; tick();
        start = 1; ev = 4'b0001;
        for (n = 1; n <= 200; n++) begin
            tick();
            if (state == 2'b10) break;
        end
        checks++; if (n != 65) begin errors++; $display("FAIL limit_edges got %0d want 65", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL limit_done got %0d want 1", done); end
        snap = 1; tick();
        for (int k = 0; k < 5; k++) begin
            rd_req = 1; rd_sel = 3'(k);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'(exp_v[k])) begin
                errors++;
                $display("FAIL limit_read sel=%0d got v=%0d d=%0d want v=1 d=%0d", k, rd_valid, rd_data, exp_v[k]);
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL limit_done_hold got %0d want 1", done); end
    endtask

    task automatic test_pause();
        clear = 1; start = 0; ev = 0; tick();
        start = 1; tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                for (int p = 0; p < 4; p++) begin
                    start = 0; ev = 4'b1111; tick();
                    checks++; if (state !== 2'b00) begin errors++; $display("FAIL pause_state got %0d want 0", state); end
                end
                start = 1; ev = 0; tick();
            end
            start = (i != 9 && i != 19);
            ev = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            checks++;
            if (state !== 2'(m_state)) begin errors++; $display("FAIL pause_run_state got %0d want %0d", state, m_state); end
        end
        ev = 0; snap = 1; tick();
        rd_req = 1; rd_sel = 3'd1; tick();
        checks++; if (rd_data !== 32'd10) begin errors++; $display("FAIL pause_ch1 got %0d want 10", rd_data); end
        rd_req = 1; rd_sel = 3'd4; tick();
        checks++; if (rd_data !== 32'd20) begin errors++; $display("FAIL pause_cycles got %0d want 20", rd_data); end
    endtask

    task automatic test_width();
        int exp_c;
`ifdef PERF_WRAP_EN
        exp_c = 20 % 16;
`else
        exp_c = 15;
`endif
        w_clear = 1; tick();
        w_start = 1; tick();
        for (int i = 0; i < 20; i++) begin
            w_ev = 4'b0100; w_start = (i != 19); tick();
        end
        w_ev = 0; w_snap = 1; tick();
        w_rd_req = 1; w_sel = 3'd2; tick();
        checks++; if (w_rd_data !== 4'(exp_c)) begin errors++; $display("FAIL width_ch2 got %0d want %0d", w_rd_data, exp_c); end
        checks++; if (w_ovf !== 5'b10100) begin errors++; $display("FAIL width_ovf got %b want 10100", w_ovf); end
    endtask

    task automatic test_snap_read();
        clear = 1; start = 0; ev = 0; tick();
        start = 1; ev = 4'b0001; tick();
        for (int i = 0; i < 7; i++) begin
            snap = (i == 2); tick();
        end
        snap = 1; rd_req = 1; rd_sel = 3'd0; tick();
        checks++; if (rd_data !== 32'd3 || rd_data !== m_rd_data[31:0]) begin errors++; $display("FAIL snapread_old got %0d want 3", rd_data); end
        rd_req = 1; rd_sel = 3'd0; tick();
        checks++; if (rd_data !== 32'd8) begin errors++; $display("FAIL snapread_new got %0d want 8", rd_data); end
        start = 0; ev = 0; tick();
    endtask

    task automatic test_clear_halt();
        int n;
        start = 1;
        for (n = 0; n < 200; n++) begin
            ev = 4'($urandom);
            tick();
            if (state == 2'b10) break;
        end
        checks++; if (state !== 2'b10 || m_state != 2) begin errors++; $display("FAIL ch_halt got %0d want 2", state); end
        clear = 1; start = 1; tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL ch_state got %0d want 0", state); end
        checks++; if (ovf !== 5'b0 || done !== 1'b0) begin errors++; $display("FAIL ch_flags got ovf=%0h done=%0d want 0", ovf, done); end
        start = 0; rd_req = 1; rd_sel = 3'd0; tick();
        checks++; if (rd_data !== 32'd8) begin errors++; $display("FAIL ch_shadow_kept got %0d want 8", rd_data); end
        snap = 1; tick();
        rd_req = 1; rd_sel = 3'd4; tick();
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL ch_live_zero got %0d want 0", rd_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 9) != 0);
            ev     = 4'($urandom);
            snap   = ($urandom_range(0, 7) == 0);
            rd_req = $urandom_range(0, 1) != 0;
            rd_sel = 3'($urandom_range(0, 7));
            clear  = ($urandom_range(0, 31) == 0);
            tick();
            checks++;
            if (state !== 2'(m_state) || done !== (m_state == 2)) begin
                errors++; $display("FAIL rnd_state i=%0d got %0d want %0d", i, state, m_state);
            end
            checks++;
            if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf i=%0d got %0h want %0h", i, ovf, m_ovf); end
            checks++;
            if (rd_valid !== m_rd_valid || rd_data !== m_rd_data[31:0]) begin
                errors++;
                $display("FAIL rnd_read i=%0d got v=%0d d=%0d want v=%0d d=%0d", i, rd_valid, rd_data, m_rd_valid, m_rd_data);
            end
        end
    endtask

    task automatic test_async_reset();
        clear = 1; tick();
        start = 1; ev = 4'b1111; tick();
        tick();
        rd_req = 1; rd_sel = 3'd0; tick();
        #2;
        rst = 0;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL arst_state got %0d want 0", state); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_rd_valid got %0d want 0", rd_valid); end
        checks++; if (w_ovf !== 5'b0 || ovf !== 5'b0) begin errors++; $display("FAIL arst_ovf got %0h want 0", w_ovf); end
        model_reset();
        start = 0; ev = 0;
        @(negedge clk);
        rst = 1;
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL arst_after got %0d want 0", state); end
    endtask

    initial begin
        model_reset();
        #12 rst = 1;
        @(posedge clk); #1;
        test_reset();
        test_limit();
        test_pause();
        test_width();
        test_snap_read();
        test_clear_halt();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
